// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the unified memory port: CPU on port 0, debug loader on port 1.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [DATA_W-1:0] wd0,
  output logic [DATA_W-1:0] rd0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] wd1,
  output logic [DATA_W-1:0] rd1,
  output logic              ack1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy,
  output logic              gnt_id
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [2:0] LAT      = 3'(READ_LAT);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       lat_we;
  logic       prev_ack0, prev_ack1;
  logic       elig0, elig1, win, capture;
`ifdef MEM_ARB_RR_EN
  logic       last_gnt;
`endif

  // a port acked last cycle may still show its old req; hold it off one cycle
  assign elig0 = req0 & ~prev_ack0;
  assign elig1 = req1 & ~prev_ack1;

  always_comb begin
    win = 1'b0;
`ifdef MEM_ARB_RR_EN
    if (elig0 & elig1) win = ~last_gnt;
    else               win = elig1;
`else
    win = ~elig0;
`endif
  end

  assign capture = ~lat_we & (((state == S_ACCESS) && (LAT == 3'd0)) ||
                              ((state == S_WAIT) && (cnt == 3'd1)));

  assign mem_we = (state == S_ACCESS) & lat_we & ~reset;
  assign ack0   = (state == S_DONE) & ~gnt_id & ~reset;
  assign ack1   = (state == S_DONE) &  gnt_id & ~reset;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      lat_we    <= 1'b0;
      gnt_id    <= 1'b0;
      mem_adr   <= '0;
      mem_wd    <= '0;
      rd0       <= '0;
      rd1       <= '0;
      prev_ack0 <= 1'b0;
      prev_ack1 <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt  <= 1'b1;
`endif
    end else begin
      prev_ack0 <= ack0;
      prev_ack1 <= ack1;
      if (capture) begin
        if (gnt_id) rd1 <= mem_rd;
        else        rd0 <= mem_rd;
      end
      case (state)
        S_IDLE: if (elig0 | elig1) begin
          gnt_id  <= win;
          lat_we  <= win ? we1  : we0;
          mem_adr <= win ? adr1 : adr0;
          mem_wd  <= win ? wd1  : wd0;
`ifdef MEM_ARB_RR_EN
          last_gnt <= win;
`endif
          state   <= S_ACCESS;
        end
        S_ACCESS: begin
          cnt   <= LAT;
          state <= (LAT == 3'd0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= S_DONE;
        end
        default: begin
          gnt_id <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed literal cases, then reactive random requesters
// checked every cycle against a transaction-level schedule model.
module tb_mem_port_arbiter;
  localparam int RL = 1;  // memory model below implements latency 0 or 1

  logic        clk = 0, reset = 1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] adr0 = 0, wd0 = 0, adr1 = 0, wd1 = 0;
  logic [31:0] rd0, rd1, mem_adr, mem_wd, mem_rd;
  logic        ack0, ack1, mem_we, busy, gnt_id;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .rd0(rd0), .ack0(ack0),
    .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .rd1(rd1), .ack1(ack1),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy), .gnt_id(gnt_id));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // memory: word per low address byte, read data delayed RL cycles from mem_adr
  logic [31:0] mem [0:255];
  logic [31:0] adr_d = 0;
  assign mem_rd = (RL == 0) ? mem[mem_adr[7:0]] : mem[adr_d[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'h44] = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_adr[7:0]] = mem_wd;
      adr_d = mem_adr;
    end
  end

  // model: a grant at cycle t owns cycles t+1 .. t+2+RL; ack on the last of them
  int          cyc = 0, free_at = 0, m_start = 0, k;
  logic        active, m_port = 0, m_we = 0, m_last = 1, pa0 = 0, pa1 = 0;
  logic        el0, el1, w, e_we, ea0, ea1, s_ack0 = 0, s_ack1 = 0;
  logic [31:0] m_adr = 0, m_wd = 0, m_data = 0, e_rd0 = 0, e_rd1 = 0, e_adr = 0, e_wd = 0;

  always @(negedge clk) begin
    active = (cyc < free_at);
    k      = cyc - m_start;
    e_we   = active && k == 1 && m_we && !reset;
    ea0    = active && k == 2 + RL && !reset && !m_port;
    ea1    = active && k == 2 + RL && !reset &&  m_port;
    if (active && k == 1) begin e_adr = m_adr; e_wd = m_wd; end
    if (active && k == 2 + RL && !m_we) begin
      if (m_port) e_rd1 = m_data; else e_rd0 = m_data;
    end
    chk("busy", busy, active);
    chk("gnt_id", gnt_id, active ? m_port : 1'b0);
    chk("mem_we", mem_we, e_we);
    chk("ack0", ack0, ea0);
    chk("ack1", ack1, ea1);
    chk("mem_adr", mem_adr, e_adr);
    chk("mem_wd", mem_wd, e_wd);
    chk("rd0", rd0, e_rd0);
    chk("rd1", rd1, e_rd1);
    s_ack0 = ack0;
    s_ack1 = ack1;
    if (reset) begin
      free_at = 0; e_rd0 = 0; e_rd1 = 0; e_adr = 0; e_wd = 0;
      m_last = 1; pa0 = 0; pa1 = 0;
    end else begin
      el0 = req0 && !pa0;
      el1 = req1 && !pa1;
      pa0 = ea0;
      pa1 = ea1;
      if (!active && (el0 || el1)) begin
`ifdef MEM_ARB_RR_EN
        w = (el0 && el1) ? (m_last == 0) : el1;
`else
        w = !el0;
`endif
        m_port  = w;
        m_last  = w;
        m_start = cyc;
        free_at = cyc + 3 + RL;
        m_we    = w ? we1  : we0;
        m_adr   = w ? adr1 : adr0;
        m_wd    = w ? wd1  : wd0;
        m_data  = mem[m_adr[7:0]];
      end
    end
    cyc++;
  end

  task automatic step; @(posedge clk); #1; endtask
  task automatic nwait(input int n); repeat (n) @(negedge clk); endtask

  logic st0 = 0, st1 = 0;

  initial begin
    step; step;
    nwait(1);
    chk("rst busy", busy, 0);
    chk("rst rd0", rd0, 0);
    chk("rst mem_adr", mem_adr, 0);
    // read port 0, t = this cycle
    step; reset = 0; req0 = 1; we0 = 0; adr0 = 32'h40;
    nwait(2);
    chk("rd t+1 mem_adr", mem_adr, 32'h40);
    chk("rd t+1 mem_we", mem_we, 0);
    nwait(2);
    chk("rd t+3 ack0", ack0, 1);
    chk("rd t+3 rd0", rd0, 32'hDEADBEEF);
    // write port 1
    step; req0 = 0; req1 = 1; we1 = 1; adr1 = 32'h80; wd1 = 32'h1234;
    nwait(2);
    chk("wr t+1 mem_we", mem_we, 1);
    chk("wr t+1 mem_adr", mem_adr, 32'h80);
    chk("wr t+1 mem_wd", mem_wd, 32'h1234);
    nwait(2);
    chk("wr t+3 ack1", ack1, 1);
    chk("wr t+3 rd1", rd1, 0);
    // reset during the ACCESS cycle of a write
    step; req1 = 0; req0 = 1; we0 = 1; adr0 = 32'h44; wd0 = 32'h5555;
    nwait(1);
    step; reset = 1;
    nwait(1);
    chk("rst-acc mem_we", mem_we, 0);
    chk("rst-acc busy", busy, 1);
    step; reset = 0;
    nwait(1);
    chk("rst-acc idle", busy, 0);
    chk("rst-acc no ack", ack0, 0);
    chk("rst-acc mem kept", mem[8'h44], 0);
    nwait(3);
    chk("rearb ack0", ack0, 1);
    chk("rearb mem", mem[8'h44], 32'h5555);
    step; req0 = 0;
    // reactive random requesters with occasional reset pulses
    for (int c = 0; c < 4000; c++) begin
      step;
      reset = ($urandom_range(0, 63) == 0);
      if (req0 && s_ack0) begin st0 = ($urandom_range(0, 3) == 0); req0 = st0; end
      else if (st0) begin st0 = 0; req0 = 0; end
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = $urandom_range(0, 1); adr0 = $urandom; wd0 = $urandom;
      end
      if (req1 && s_ack1) begin st1 = ($urandom_range(0, 3) == 0); req1 = st1; end
      else if (st1) begin st1 = 0; req1 = 0; end
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = $urandom_range(0, 1); adr1 = $urandom; wd1 = $urandom;
      end
    end
    nwait(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
